// File: rtl/branch_predictor.sv
// Two-bit counter / tagged BTB branch predictor with EX-stage resolution check.
// Optional statistics counters are built when BP_STATS_EN is defined.
module branch_predictor #(
    parameter int INDEX_BITS = 4,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count
`endif
);

    localparam int              ENTRIES = 1 << INDEX_BITS;
    localparam int              TAG_W   = XLEN - INDEX_BITS - 2;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [1:0]       r_ctr        [ENTRIES];
    logic             r_btb_valid  [ENTRIES];
    logic [TAG_W-1:0] r_btb_tag    [ENTRIES];
    logic [XLEN-1:0]  r_btb_target [ENTRIES];

    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [INDEX_BITS-1:0] w_eidx;
    logic [TAG_W-1:0]      w_etag;
    logic                  w_hit;
    logic                  w_unused_bits;

    assign w_idx  = if_pc[INDEX_BITS+1:2];
    assign w_tag  = if_pc[XLEN-1:INDEX_BITS+2];
    assign w_eidx = ex_pc[INDEX_BITS+1:2];
    assign w_etag = ex_pc[XLEN-1:INDEX_BITS+2];
    assign w_unused_bits = ^{if_pc[1:0], ex_pc[1:0]};

    // Zero-latency lookup; reads pre-update state when training the same index.
    always_comb begin
        w_hit       = r_btb_valid[w_idx] && (r_btb_tag[w_idx] == w_tag);
        pred_taken  = w_hit && r_ctr[w_idx][1];
        pred_target = if_pc + PC_STEP;
        if (pred_taken) begin
            pred_target = r_btb_target[w_idx];
        end else begin
            pred_target = if_pc + PC_STEP;
        end
    end

    // Resolution check; redirect is always the architecturally correct next PC.
    always_comb begin
        mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                                   (ex_taken && (ex_pred_target != ex_target)));
        redirect_pc = ex_pc + PC_STEP;
        if (ex_taken) begin
            redirect_pc = ex_target;
        end else begin
            redirect_pc = ex_pc + PC_STEP;
        end
    end

    // Table training: counters shared across tags, BTB replaced only on taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i]        <= 2'b01;
                r_btb_valid[i]  <= 1'b0;
                r_btb_tag[i]    <= '0;
                r_btb_target[i] <= '0;
            end
        end else if (ex_valid) begin
            if (ex_taken) begin
                if (r_ctr[w_eidx] != 2'b11) begin
                    r_ctr[w_eidx] <= r_ctr[w_eidx] + 2'b01;
                end
                r_btb_valid[w_eidx]  <= 1'b1;
                r_btb_tag[w_eidx]    <= w_etag;
                r_btb_target[w_eidx] <= ex_target;
            end else if (r_ctr[w_eidx] != 2'b00) begin
                r_ctr[w_eidx] <= r_ctr[w_eidx] - 2'b01;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] r_branch_count;
    logic [31:0] r_mispredict_count;

    // Free-running resolution statistics, wrapping at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_count     <= 32'd0;
            r_mispredict_count <= 32'd0;
        end else begin
            if (ex_valid) begin
                r_branch_count <= r_branch_count + 32'd1;
            end
            if (mispredict) begin
                r_mispredict_count <= r_mispredict_count + 32'd1;
            end
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus queues expectations, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;
`endif

    branch_predictor #(.INDEX_BITS(4), .XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc)
`ifdef BP_STATS_EN
        ,
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
`endif
    );

    typedef struct {
        string       name;
        int          cyc;
        bit          chk_p;
        logic        xpt;
        logic [31:0] xptgt;
        bit          chk_m;
        logic        xm;
        bit          chk_r;
        logic [31:0] xr;
        bit          chk_s;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due for the current cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.chk_p) begin
                n_checks++;
                if (pred_taken !== e.xpt) begin
                    n_fail++;
                    $display("FAIL %s pred_taken: got %0b want %0b", e.name, pred_taken, e.xpt);
                end
                n_checks++;
                if (pred_target !== e.xptgt) begin
                    n_fail++;
                    $display("FAIL %s pred_target: got %h want %h", e.name, pred_target, e.xptgt);
                end
            end
            if (e.chk_m) begin
                n_checks++;
                if (mispredict !== e.xm) begin
                    n_fail++;
                    $display("FAIL %s mispredict: got %0b want %0b", e.name, mispredict, e.xm);
                end
            end
            if (e.chk_r) begin
                n_checks++;
                if (redirect_pc !== e.xr) begin
                    n_fail++;
                    $display("FAIL %s redirect_pc: got %h want %h", e.name, redirect_pc, e.xr);
                end
            end
`ifdef BP_STATS_EN
            if (e.chk_s) begin
                n_checks++;
                if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
                    n_fail++;
                    $display("FAIL %s stats: got %0d/%0d want 0/0", e.name, branch_count, mispredict_count);
                end
            end
`endif
        end
    end

    task automatic set_in(input logic [31:0] ipc, input logic ev, input logic [31:0] epc,
                          input logic et, input logic [31:0] etgt,
                          input logic ept, input logic [31:0] eptgt);
        if_pc          = ipc;
        ex_valid       = ev;
        ex_pc          = epc;
        ex_taken       = et;
        ex_target      = etgt;
        ex_pred_taken  = ept;
        ex_pred_target = eptgt;
    endtask

    task automatic expect_q(input string nm, input bit cp, input logic xpt, input logic [31:0] xptgt,
                            input bit cm, input logic xm, input bit cr, input logic [31:0] xr,
                            input bit cs);
        exp_t e;
        e.name = nm; e.cyc = cyc;
        e.chk_p = cp; e.xpt = xpt; e.xptgt = xptgt;
        e.chk_m = cm; e.xm = xm; e.chk_r = cr; e.xr = xr; e.chk_s = cs;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Lookup-only cycle (no resolution).
    task automatic look(input string nm, input logic [31:0] ipc, input logic xpt, input logic [31:0] xptgt);
        set_in(ipc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_q(nm, 1'b1, xpt, xptgt, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        next_cycle();
    endtask

    // Resolution cycle with the lookup parked on an unrelated index.
    task automatic resolve(input string nm, input logic [31:0] epc, input logic et, input logic [31:0] etgt,
                           input logic ept, input logic [31:0] eptgt, input logic xm, input logic [31:0] xr);
        set_in(32'h0000_0008, 1'b1, epc, et, etgt, ept, eptgt);
        expect_q(nm, 1'b0, 1'b0, 32'h0, 1'b1, xm, 1'b1, xr, 1'b0);
        next_cycle();
    endtask

    initial begin
        cyc = 0; n_checks = 0; n_fail = 0;
        rst = 1'b1;
        set_in(32'h0000_0100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        next_cycle();
        expect_q("in_reset", 1'b1, 1'b0, 32'h0000_0104, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        next_cycle();
        rst = 1'b0;

        look("post_rst_100", 32'h0000_0100, 1'b0, 32'h0000_0104);
        look("post_rst_13c", 32'h0000_013C, 1'b0, 32'h0000_0140);
        look("pc_wrap",      32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

        // First taken branch, with a same-cycle lookup of the same index.
        set_in(32'h0000_0100, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0080, 1'b0, 32'h0000_0104);
        expect_q("first_taken", 1'b1, 1'b0, 32'h0000_0104, 1'b1, 1'b1, 1'b1, 32'h0000_0080, 1'b0);
        next_cycle();
        look("after_first", 32'h0000_0100, 1'b1, 32'h0000_0080);

        for (int i = 0; i < 3; i++)
            resolve("sat_taken", 32'h0000_0100, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0080, 1'b0, 32'h0000_0080);
        resolve("nt_1", 32'h0000_0100, 1'b0, 32'h0000_0080, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0104);
        look("hyst_still_t", 32'h0000_0100, 1'b1, 32'h0000_0080);
        resolve("nt_2", 32'h0000_0100, 1'b0, 32'h0000_0080, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0104);
        look("now_nt", 32'h0000_0100, 1'b0, 32'h0000_0104);

        resolve("retrain_1", 32'h0000_0100, 1'b1, 32'h0000_0080, 1'b0, 32'h0000_0104, 1'b1, 32'h0000_0080);
        resolve("retrain_2", 32'h0000_0100, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0080, 1'b0, 32'h0000_0080);
        look("alias_miss_140", 32'h0000_0140, 1'b0, 32'h0000_0144);
        resolve("alias_train", 32'h0000_0140, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0144, 1'b1, 32'h0000_0200);
        look("alias_old_miss", 32'h0000_0100, 1'b0, 32'h0000_0104);
        look("alias_new_hit",  32'h0000_0140, 1'b1, 32'h0000_0200);

        resolve("wrong_target", 32'h0000_0140, 1'b1, 32'h0000_0090, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0090);

        // Invalid resolution: no mispredict and no training.
        set_in(32'h0000_0140, 1'b0, 32'h0000_0180, 1'b1, 32'h0000_0300, 1'b0, 32'h0000_0000);
        expect_q("ex_invalid", 1'b1, 1'b1, 32'h0000_0090, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        next_cycle();
        look("no_train_idle", 32'h0000_0140, 1'b1, 32'h0000_0090);

        resolve("redirect_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0000);

        // Async reset asserted mid-cycle while a taken branch is resolving.
        set_in(32'h0000_0140, 1'b1, 32'h0000_0140, 1'b1, 32'h0000_0500, 1'b0, 32'h0000_0144);
        #2;
        rst = 1'b1;
        expect_q("async_rst", 1'b1, 1'b0, 32'h0000_0144, 1'b1, 1'b1, 1'b1, 32'h0000_0500, 1'b1);
        next_cycle();
        rst = 1'b0;
        look("rst_dropped_wr", 32'h0000_0140, 1'b0, 32'h0000_0144);
        look("rst_100_miss",   32'h0000_0100, 1'b0, 32'h0000_0104);

        next_cycle();
        next_cycle();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
